// File: rtl/booth_mul_seq_if.sv
// Handshake and operand/product bundle between the datapath control and the
// Booth multiplier.
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Zhigh;
    logic [WIDTH-1:0] Zlow;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, Zhigh, Zlow
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, Zhigh, Zlow
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Multi-cycle signed multiplier using radix-4 Booth recoding; one bit pair per
// CALC cycle, product loaded into Zhigh/Zlow on the final iteration.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic           Clock,
    input  logic           clear,
    booth_mul_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int PW    = WIDTH + 2;
    localparam int ITERS = WIDTH / 2;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    logic [1:0]       state;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    p_hi;
    logic [WIDTH-1:0] p_lo;
    logic             guard;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] zhigh;
    logic [WIDTH-1:0] zlow;

    logic [PW-1:0]    multiple;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    p_hi_nx;
    logic [WIDTH-1:0] p_lo_nx;

    // Two guard bits on the accumulator keep +/-2A of the most negative operand exact.
    always_comb begin
        multiple = '0;
        case ({p_lo[1:0], guard})
            3'b001, 3'b010: multiple = a_ext;
            3'b011:         multiple = a_ext << 1;
            3'b100:         multiple = -(a_ext << 1);
            3'b101, 3'b110: multiple = -a_ext;
            default:        multiple = '0;
        endcase
        sum     = p_hi + multiple;
        p_hi_nx = {{2{sum[PW-1]}}, sum[PW-1:2]};
        p_lo_nx = {sum[1:0], p_lo[WIDTH-1:2]};
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            state <= IDLE;
            a_ext <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            guard <= 1'b0;
            cnt   <= '0;
            zhigh <= '0;
            zlow  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_ext <= {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
                        p_hi  <= '0;
                        p_lo  <= bus.multiplier;
                        guard <= 1'b0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    p_hi  <= p_hi_nx;
                    p_lo  <= p_lo_nx;
                    guard <= p_lo[1];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        zhigh <= p_hi_nx[WIDTH-1:0];
                        zlow  <= p_lo_nx;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state == CALC) || (state == DONE);
    assign bus.done  = (state == DONE);
    assign bus.Zhigh = zhigh;
    assign bus.Zlow  = zlow;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corners plus random operands
// checked against a plain 64-bit signed multiply.
module tb_booth_mul_seq;
    logic clk = 1'b0;
    logic clear;
    int   errors = 0;
    int   checks = 0;

    booth_mul_seq_if #(.WIDTH(32)) mif ();

    booth_mul_seq #(.WIDTH(32)) dut (
        .Clock (clk),
        .clear (clear),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    // Drives one operation and observes until done has come and gone.
    // lat = edges from the start edge to the edge that raised done (-1 if never).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cycles, output int done_cnt);
        @(negedge clk);
        mif.start = 1'b1; mif.multiplicand = a; mif.multiplier = b;
        @(posedge clk); #1;
        mif.start = 1'b0; mif.multiplicand = $urandom; mif.multiplier = $urandom;
        lat = -1; busy_cycles = 0; done_cnt = 0;
        if (mif.busy && !mif.done) busy_cycles++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (mif.done) begin
                done_cnt++;
                if (lat < 0) lat = i;
            end else if (mif.busy && lat < 0) begin
                busy_cycles++;
            end
            if (lat >= 0 && i >= lat + 2) break;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", mif.busy); end
        checks++; if (mif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", mif.done); end
        checks++; if (mif.Zhigh !== 32'h0) begin errors++; $display("FAIL reset_zhigh: got %h expected 00000000", mif.Zhigh); end
        checks++; if (mif.Zlow !== 32'h0) begin errors++; $display("FAIL reset_zlow: got %h expected 00000000", mif.Zlow); end
    endtask

    task automatic test_basic();
        int lat, bc, dc;
        run_op(32'h8FFFFFFF, 32'h00000003, lat, bc, dc);
        checks++; if (lat !== 16) begin errors++; $display("FAIL basic_latency: got %0d expected 16", lat); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", dc); end
        checks++; if (mif.Zhigh !== 32'hFFFFFFFE) begin errors++; $display("FAIL basic_zhigh: got %h expected fffffffe", mif.Zhigh); end
        checks++; if (mif.Zlow !== 32'hAFFFFFFD) begin errors++; $display("FAIL basic_zlow: got %h expected affffffd", mif.Zlow); end
    endtask

    task automatic test_corners();
        logic [31:0] ops [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [63:0] exp_p [3] = '{64'h40000000_00000000, 64'h00000000_00000001, 64'h3FFFFFFF_00000001};
        int lat, bc, dc;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], ops[i], lat, bc, dc);
            checks++;
            if ({mif.Zhigh, mif.Zlow} !== exp_p[i] || lat !== 16) begin
                errors++;
                $display("FAIL corner_%0d: got %h lat %0d expected %h lat 16", i, {mif.Zhigh, mif.Zlow}, lat, exp_p[i]);
            end
        end
    endtask

    task automatic test_zero_multiplier();
        int lat, bc, dc;
        run_op(32'h00000027, 32'h00000000, lat, bc, dc);
        checks++; if (bc !== 16) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 16", bc); end
        checks++; if (lat !== 16) begin errors++; $display("FAIL zero_latency: got %0d expected 16", lat); end
        checks++; if ({mif.Zhigh, mif.Zlow} !== 64'h0) begin errors++; $display("FAIL zero_product: got %h expected 0", {mif.Zhigh, mif.Zlow}); end
    endtask

    task automatic test_ignored_start();
        int dc = 0;
        @(negedge clk);
        mif.start = 1'b1; mif.multiplicand = 32'd5; mif.multiplier = 32'd7;
        @(posedge clk); #1;
        mif.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 mif.start = 1'b1; mif.multiplicand = 32'd2; mif.multiplier = 32'd2;
        @(posedge clk); #1;
        mif.start = 1'b0;
        if (mif.done) dc++;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (mif.done) dc++;
        end
        checks++; if (dc !== 1) begin errors++; $display("FAIL ignored_done_pulses: got %0d expected 1", dc); end
        checks++; if (mif.Zlow !== 32'h23) begin errors++; $display("FAIL ignored_zlow: got %h expected 00000023", mif.Zlow); end
        checks++; if (mif.Zhigh !== 32'h0) begin errors++; $display("FAIL ignored_zhigh: got %h expected 00000000", mif.Zhigh); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mif.multiplicand = $urandom; mif.multiplier = $urandom;
        end
        checks++;
        if ({mif.Zhigh, mif.Zlow} !== 64'h23 || mif.busy !== 1'b0) begin
            errors++; $display("FAIL hold_product: got %h busy %b expected 23 busy 0", {mif.Zhigh, mif.Zlow}, mif.busy);
        end
    endtask

    task automatic test_clear_abort();
        int dc = 0;
        int lat, bc;
        logic [31:0] a, b;
        @(negedge clk);
        mif.start = 1'b1; mif.multiplicand = 32'h12345678; mif.multiplier = 32'h9ABCDEF0;
        @(posedge clk); #1;
        mif.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", mif.busy); end
        checks++; if ({mif.Zhigh, mif.Zlow} !== 64'h0) begin errors++; $display("FAIL abort_product: got %h expected 0", {mif.Zhigh, mif.Zlow}); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (mif.done || mif.busy) dc++;
        end
        checks++; if (dc !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dc); end
        a = $urandom; b = $urandom;
        run_op(a, b, lat, bc, dc);
        checks++;
        if ({mif.Zhigh, mif.Zlow} !== ref_mul(a, b) || lat !== 16) begin
            errors++; $display("FAIL abort_restart: got %h lat %0d expected %h lat 16", {mif.Zhigh, mif.Zlow}, lat, ref_mul(a, b));
        end
    endtask

    task automatic test_random();
        int lat, bc, dc;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom;
            if (i % 4 == 1) a = 32'h80000000;
            if (i % 6 == 2) b = 32'h80000000;
            if (i % 5 == 3) b = {31'h0, b[0]} - 32'd1;
            run_op(a, b, lat, bc, dc);
            checks++;
            if ({mif.Zhigh, mif.Zlow} !== ref_mul(a, b) || lat !== 16 || dc !== 1) begin
                errors++;
                $display("FAIL random_%0d: A=%h B=%h got %h lat %0d dones %0d expected %h lat 16 dones 1",
                         i, a, b, {mif.Zhigh, mif.Zlow}, lat, dc, ref_mul(a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        bit seen;
        @(negedge clk);
        a = $urandom; b = $urandom;
        mif.start = 1'b1; mif.multiplicand = a; mif.multiplier = b;
        for (int op = 0; op < 3; op++) begin
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(posedge clk); #1;
                if (mif.done) seen = 1'b1;
            end
            checks++;
            if (!seen || {mif.Zhigh, mif.Zlow} !== ref_mul(a, b)) begin
                errors++;
                $display("FAIL b2b_%0d: done %b got %h expected %h", op, seen, {mif.Zhigh, mif.Zlow}, ref_mul(a, b));
            end
            a = $urandom; b = $urandom;
            mif.multiplicand = a; mif.multiplier = b;
        end
        mif.start = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    initial begin
        clear = 1'b0;
        mif.start = 1'b0;
        mif.multiplicand = '0;
        mif.multiplier = '0;
        test_reset();
        test_basic();
        test_corners();
        test_zero_multiplier();
        test_ignored_start();
        test_clear_abort();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
